ps2_key_event_rx: RTL and testbench

//  Parametrised PS/2 keyboard receiver producing decoded key events for the game logic.
//  - Samples kb_clk/data through a synchroniser and checks start, odd-parity and stop bits.
//  - Folds scan-code prefixes into flags: E0 (extended), F0 (break).
//  - Buffers complete make/break events in a FIFO drained through a valid/ready handshake.
//  - Sits between the board PS/2 pins and the input/control FSM; replaces the single-byte receiver.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_event_fifo.sv | 73 +++++++
 rtl/ps2_key_event_rx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared types and constants for the PS/2 key event receiver.
// Rev    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } ps2_event_t;

    // Saturating 8-bit accumulate used by the optional error counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module : ps2_event_fifo
// Brief  : Show-ahead event FIFO; drops pushes when full unless a pop frees a slot.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     overflow,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign valid  = (r_level != '0);
    assign w_full = (r_level == LVL_W'(DEPTH));
    assign w_pop  = pop & valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= push & w_full & ~w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign head     = valid ? r_mem[r_rd_ptr] : '0;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_rx.sv
`default_nettype none
// ============================================================================
// Module : ps2_key_event_rx
// Brief  : PS/2 keyboard frame receiver folding E0/F0 prefixes into key events.
//          Optional macro PS2_ERR_STATS_EN adds a saturating err_count output.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          kb_clk,
    input  logic                          data,
    output logic [7:0]                    ev_code,
    output logic                          ev_make,
    output logic                          ev_ext,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          overflow
`ifdef PS2_ERR_STATS_EN
    ,
    output logic [7:0]                    err_count
`endif
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Synchroniser flops idle high so reset release never looks like a fall.
    logic [SYNC_STAGES-1:0] r_kb_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_kb_clk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kb_clk_sync <= '1;
            r_data_sync   <= '1;
            r_kb_clk_prev <= 1'b1;
        end else begin
            r_kb_clk_sync <= {r_kb_clk_sync[SYNC_STAGES-2:0], kb_clk};
            r_data_sync   <= {r_data_sync[SYNC_STAGES-2:0], data};
            r_kb_clk_prev <= r_kb_clk_sync[SYNC_STAGES-1];
        end
    end

    logic w_fall;
    logic w_data_s;
    assign w_fall   = r_kb_clk_prev & ~r_kb_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];

    ps2_state_t       r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par_ok;
    logic             r_ext;
    logic             r_brk;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_push;
    ps2_event_t       r_push_ev;
    logic             r_frame_err;

    logic [TO_W-1:0]  w_to_next;
    assign w_to_next = r_to_cnt + TO_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_ok    <= 1'b0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_to_cnt    <= '0;
            r_push      <= 1'b0;
            r_push_ev   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_to_cnt <= '0;
                if (w_fall && !w_data_s) begin
                    r_state   <= ST_DATA;
                    r_bit_cnt <= '0;
                end
            end else if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    ST_DATA: begin
                        r_shift   <= {w_data_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_par_ok <= ^r_shift ^ w_data_s;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (r_par_ok && w_data_s) begin
                            if (r_shift == PS2_PFX_EXT) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == PS2_PFX_BRK) begin
                                r_brk <= 1'b1;
                            end else begin
                                r_push    <= 1'b1;
                                r_push_ev <= '{ext: r_ext, make: ~r_brk, code: r_shift};
                                r_ext     <= 1'b0;
                                r_brk     <= 1'b0;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_ext       <= 1'b0;
                            r_brk       <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_to_next == C_TO_LAST) begin
                // Keyboard stalled mid-frame: abandon it and any pending prefix.
                r_state     <= ST_IDLE;
                r_to_cnt    <= '0;
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end else begin
                r_to_cnt <= w_to_next;
            end
        end
    end

    ps2_event_t w_head;
    logic       w_overflow;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_event_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_push),
        .push_data (r_push_ev),
        .overflow  (w_overflow),
        .pop       (ev_ready),
        .valid     (ev_valid),
        .head      (w_head),
        .level     (fifo_level)
    );

    assign ev_code   = w_head.code;
    assign ev_make   = w_head.make;
    assign ev_ext    = w_head.ext;
    assign frame_err = r_frame_err;
    assign overflow  = w_overflow;

`ifdef PS2_ERR_STATS_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_frame_err || w_overflow) begin
            r_err_count <= sat_add8(r_err_count,
                                    {r_frame_err & w_overflow, r_frame_err ^ w_overflow});
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2_key_event_rx
// Brief  : Directed and randomized PS/2 frames checked against a queue-based event model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ps2_key_event_rx;
    localparam int SYNC  = 3;
    localparam int DEPTH = 8;
    localparam int TMO   = 50;
    localparam int HALF  = 8;
    // Pin fall -> internal fall registered after SYNC+1 edges.
    localparam int VALID_LAT = SYNC + 2;
    localparam int TO_LAT    = SYNC + 1 + TMO - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       kb_clk;
    logic       data;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_make;
    logic       ev_ext;
    logic       ev_valid;
    logic [3:0] fifo_level;
    logic       frame_err;
    logic       overflow;
`ifdef PS2_ERR_STATS_EN
    logic [7:0] err_count;
`endif

    ps2_key_event_rx #(
        .SYNC_STAGES    (SYNC),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .kb_clk     (kb_clk),
        .data       (data),
        .ev_code    (ev_code),
        .ev_make    (ev_make),
        .ev_ext     (ev_ext),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .overflow   (overflow)
`ifdef PS2_ERR_STATS_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of pending key events plus prefix flags.
    typedef struct {
        logic [7:0] code;
        logic       make;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    bit  m_ext = 1'b0;
    bit  m_brk = 1'b0;
    int  exp_err = 0, exp_ovf = 0, obs_err = 0, obs_ovf = 0, n_pops = 0;
    int  cyc = 0, t_fall = 0, t_rise = 0;
    bit  prev_valid = 1'b0;
    bit  rnd_ready_en = 1'b0;
    bit  fixed_ready = 1'b1;

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() >= DEPTH) exp_ovf++;
            else exp_q.push_back('{code: b, make: !m_brk, ext: m_ext});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    always @(posedge clk) cyc++;

    initial begin
        ev_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ev_ready = rnd_ready_en ? ($urandom_range(0, 3) != 0) : fixed_ready;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (ev_valid && !prev_valid) t_rise = cyc;
            prev_valid = ev_valid;
            if (frame_err) obs_err++;
            if (overflow) obs_ovf++;
            if (ev_valid && ev_ready) begin
                check("ev_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("event", {22'd0, ev_ext, ev_make, ev_code},
                          {22'd0, mon_e.ext, mon_e.make, mon_e.code});
                end
                n_pops++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data = b;
        wait_cyc(HALF);
        kb_clk = 1'b0;
        t_fall = cyc;
        wait_cyc(HALF);
        kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        model_frame(b, !bad_par && !bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(!bad_stop);
        data = 1'b1;
        wait_cyc(6);
    endtask

    int  err0, pop0, ovf0;
    bit  seen;

    initial begin
        rst    = 1'b1;
        kb_clk = 1'b1;
        data   = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(2);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_code", 32'(ev_code), 32'd0);

        // Single make code and its latency.
        fixed_ready = 1'b1;
        wait_cyc(2);
        pop0 = n_pops;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("lat_valid", 32'(t_rise - t_fall), 32'(VALID_LAT));
        check("pops_1c", 32'(n_pops - pop0), 32'd1);

        // Extended break sequence.
        pop0 = n_pops; err0 = obs_err;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("pops_e0f075", 32'(n_pops - pop0), 32'd1);
        check("err_e0f075", 32'(obs_err - err0), 32'd0);

        // Bad parity then a valid break.
        pop0 = n_pops; err0 = obs_err;
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("err_badpar", 32'(obs_err - err0), 32'd1);
        check("pops_badpar", 32'(n_pops - pop0), 32'd1);

        // Overflow with consumer stalled.
        fixed_ready = 1'b0;
        wait_cyc(2);
        pop0 = n_pops; ovf0 = obs_ovf;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        check("ovf_level", 32'(fifo_level), 32'(DEPTH));
        check("ovf_pulse", 32'(obs_ovf - ovf0), 32'd1);
        fixed_ready = 1'b1;
        wait_cyc(20);
        check("ovf_drain", 32'(n_pops - pop0), 32'(DEPTH));
        check("ovf_empty", 32'(fifo_level), 32'd0);

        // Keyboard clock stalls after four data bits.
        err0 = obs_err;
        model_frame(8'h00, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        data = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (frame_err) seen = 1'b1;
        end
        check("to_seen", 32'(seen), 32'd1);
        if (seen) check("to_latency", 32'(cyc - t_fall), 32'(TO_LAT));
        wait_cyc(3);
        check("to_errcnt", 32'(obs_err - err0), 32'd1);
        pop0 = n_pops;
        send_frame(8'h29, 1'b0, 1'b0);
        check("to_recover", 32'(n_pops - pop0), 32'd1);

        // Reset mid-frame with entries held.
        fixed_ready = 1'b0;
        wait_cyc(2);
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h13, 1'b0, 1'b0);
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_rst_errs", 32'(obs_err), 32'(exp_err));
        check("pre_rst_ovfs", 32'(obs_ovf), 32'(exp_ovf));
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_level", 32'(fifo_level), 32'd0);
        check("rst_mid_valid", 32'(ev_valid), 32'd0);
        exp_q.delete();
        m_ext = 1'b0; m_brk = 1'b0;
        exp_err = 0; exp_ovf = 0; obs_err = 0; obs_ovf = 0;
        data = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        fixed_ready = 1'b1;
        wait_cyc(3);
        pop0 = n_pops;
        send_frame(8'h2A, 1'b0, 1'b0);
        check("post_rst_err", 32'(obs_err), 32'd0);
        check("post_rst_pop", 32'(n_pops - pop0), 32'd1);

        // Randomized traffic with idle glitches and corrupted frames.
        rnd_ready_en = 1'b1;
        for (int n = 0; n < 48; n++) begin
            logic [7:0] b;
            int r;
            bit bp, bs;
            r  = $urandom_range(0, 9);
            b  = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) send_bit(1'b1);
            send_frame(b, bp, bs);
        end
        rnd_ready_en = 1'b0;
        fixed_ready  = 1'b1;
        wait_cyc(20);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("final_level", 32'(fifo_level), 32'd0);
        check("final_errs", 32'(obs_err), 32'(exp_err));
        check("final_ovfs", 32'(obs_ovf), 32'(exp_ovf));
`ifdef PS2_ERR_STATS_EN
        check("err_count", 32'(err_count),
              32'((exp_err + exp_ovf > 255) ? 255 : exp_err + exp_ovf));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
